// File: rtl/coeff_bank_dbuf_if.sv
// Serial coefficient-load port of the double-buffered coefficient bank.
// The master drives load/commit requests; the slave reports handshake and load status.
interface coeff_bank_dbuf_if #(
  parameter int COEFF_BITS = 16
);
  logic                  cfg_start;
  logic                  cfg_valid;
  logic                  cfg_ready;
  logic [COEFF_BITS-1:0] cfg_data;
  logic                  cfg_commit;
  logic                  cfg_err;
  logic                  load_done;
  logic                  swap_pending;

  modport master (
    output cfg_start, cfg_valid, cfg_data, cfg_commit,
    input  cfg_ready, cfg_err, load_done, swap_pending
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, cfg_commit,
    output cfg_ready, cfg_err, load_done, swap_pending
  );
endinterface

// File: rtl/coeff_bank_dbuf.sv
// Double-buffered multi-band FIR coefficient store: serial load into the shadow bank,
// swap at a frame boundary, and one registered parallel read across all bands.
module coeff_bank_dbuf #(
  parameter int NUM_BANDS      = 8,
  parameter int NUMBER_OF_TAPS = 64,
  parameter int COUNTER_BITS   = 6,
  parameter int COEFF_BITS     = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  coeff_bank_dbuf_if.slave                cfg,
  input  logic                            frame_sync,
  input  logic [COUNTER_BITS-1:0]         current_count,
  output logic [NUM_BANDS*COEFF_BITS-1:0] coeff
);
  localparam int BAND_BITS = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FULL, PENDING} state_t;

  state_t                  state;
  logic                    active_sel;
  // Write pointer kept as (band, tap) so the word order band*TAPS+tap needs no divider.
  logic [BAND_BITS-1:0]    wr_band;
  logic [COUNTER_BITS-1:0] wr_tap;
  logic                    last_word;
  logic                    wr_en;
  logic                    rd_in_range;

  assign last_word   = (wr_band == BAND_BITS'(NUM_BANDS-1)) &&
                       (wr_tap  == COUNTER_BITS'(NUMBER_OF_TAPS-1));
  assign wr_en       = (state == LOAD) && cfg.cfg_valid && !cfg.cfg_start;
  assign rd_in_range = int'(current_count) < NUMBER_OF_TAPS;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      active_sel       <= 1'b0;
      wr_band          <= '0;
      wr_tap           <= '0;
      cfg.cfg_ready    <= 1'b0;
      cfg.load_done    <= 1'b0;
      cfg.swap_pending <= 1'b0;
      cfg.cfg_err      <= 1'b0;
    end else if (cfg.cfg_start) begin
      // Restart wins over commit and frame_sync; shadow contents are left as-is.
      state            <= LOAD;
      wr_band          <= '0;
      wr_tap           <= '0;
      cfg.cfg_ready    <= 1'b1;
      cfg.load_done    <= 1'b0;
      cfg.swap_pending <= 1'b0;
      cfg.cfg_err      <= 1'b0;
    end else begin
      case (state)
        IDLE: ;
        LOAD: begin
          if (cfg.cfg_commit) cfg.cfg_err <= 1'b1;
          if (cfg.cfg_valid) begin
            if (last_word) begin
              state         <= FULL;
              cfg.cfg_ready <= 1'b0;
              cfg.load_done <= 1'b1;
            end else if (wr_tap == COUNTER_BITS'(NUMBER_OF_TAPS-1)) begin
              wr_tap  <= '0;
              wr_band <= wr_band + 1'b1;
            end else begin
              wr_tap <= wr_tap + 1'b1;
            end
          end
        end
        FULL: if (cfg.cfg_commit) begin
          state            <= PENDING;
          cfg.load_done    <= 1'b0;
          cfg.swap_pending <= 1'b1;
        end
        PENDING: if (frame_sync) begin
          state            <= IDLE;
          active_sel       <= ~active_sel;
          cfg.swap_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    logic [NUMBER_OF_TAPS-1:0][COEFF_BITS-1:0] bank0, bank1;
    logic [COEFF_BITS-1:0]                     rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bank0 <= '0;
        bank1 <= '0;
        rd_q  <= '0;
      end else begin
        if (wr_en && wr_band == BAND_BITS'(b)) begin
          if (active_sel) bank0[wr_tap] <= cfg.cfg_data;
          else            bank1[wr_tap] <= cfg.cfg_data;
        end
        // active_sel is sampled before its toggle, so the swap cycle still reads the old bank.
        if (!rd_in_range)    rd_q <= '0;
        else if (active_sel) rd_q <= bank1[current_count];
        else                 rd_q <= bank0[current_count];
      end
    end

    assign coeff[b*COEFF_BITS +: COEFF_BITS] = rd_q;
  end
endmodule

// File: doc/coeff_bank_dbuf.md
Name: coeff_bank_dbuf

Overview:
- Multi-band, double-buffered FIR coefficient store for the 8-band equalizer.
- Coefficients are loaded serially into a shadow bank over a valid/ready port while filtering continues from the active bank.
- A commit request swaps the shadow and active banks at the next sample-frame boundary, so no convolution ever mixes old and new taps.
- One registered read returns the tap selected by the shared tap counter for every band in parallel.

Parameters:
- NUM_BANDS, 8, number of parallel filters/bands.
- NUMBER_OF_TAPS, 64, taps per band.
- COUNTER_BITS, 6, width of tap index; must satisfy 2^COUNTER_BITS >= NUMBER_OF_TAPS.
- COEFF_BITS, 16, signed coefficient width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_start  in  1  pulse: begin a new shadow load, pointer to word 0.
- cfg_valid  in  1  cfg_data holds a coefficient word.
- cfg_ready  out  1  shadow bank accepts a word this cycle.
- cfg_data  in  COEFF_BITS  signed coefficient word.
- cfg_commit  in  1  pulse: request bank swap.
- cfg_err  out  1  sticky: commit requested before load complete; cleared by cfg_start.
- load_done  out  1  shadow bank fully written, not yet committed.
- swap_pending  out  1  commit accepted, waiting for frame_sync.
- frame_sync  in  1  pulse: first cycle of a new sample computation.
- current_count  in  COUNTER_BITS  tap index from the shared counter.
- coeff  out  NUM_BANDS*COEFF_BITS  band b tap at bits [(b+1)*COEFF_BITS-1 : b*COEFF_BITS].

Behaviour:
- Storage: two banks of NUM_BANDS*NUMBER_OF_TAPS words; active_sel selects the active bank, the other is the shadow.
- Reset (async, rst_n=0): both banks all zero, active_sel=0, state IDLE, write pointer 0, coeff=0, cfg_ready=0, load_done=0, swap_pending=0, cfg_err=0.
- States:
  - IDLE: cfg_ready=0. cfg_start -> LOAD.
  - LOAD: cfg_ready=1. Each cycle with cfg_valid&cfg_ready writes cfg_data to shadow[ptr] and increments ptr.
    - Word order: band 0 taps 0..N-1, then band 1, and so on; word = band*NUMBER_OF_TAPS + tap.
    - Write of the last word (ptr = NUM_BANDS*NUMBER_OF_TAPS-1) -> FULL.
    - cfg_commit in LOAD: ignored, sets cfg_err.
  - FULL: load_done=1, cfg_ready=0. cfg_commit -> PENDING.
  - PENDING: swap_pending=1, cfg_ready=0. On frame_sync: toggle active_sel -> IDLE.
    - frame_sync and cfg_commit in the same FULL cycle: go to PENDING only; the swap waits for the next frame_sync.
- cfg_start in any state (including mid-LOAD, FULL, PENDING):
  - Aborts the current load or pending swap.
  - ptr=0, cfg_err=0, -> LOAD.
  - Shadow contents are not cleared.
  - cfg_start has priority over cfg_commit and frame_sync in the same cycle.
- Read path:
  - coeff registered, latency 1 cycle: coeff(t+1) = active bank taps at current_count(t), all bands.
  - On the swap cycle the read still uses the old bank; the new bank is visible from the following read.
  - current_count >= NUMBER_OF_TAPS returns 0 for all bands.
- Writes never touch the active bank; the read output is unaffected by loading.
- Arithmetic: no sign/width conversion; words are stored and returned bit-exact.
- Write pointer width is clog2(NUM_BANDS*NUMBER_OF_TAPS); no wrap, because the FSM leaves LOAD at the last word.

Test Plan:
- Reset, count=5 -> coeff=0 on all 8 bands; cfg_ready=0; all flags 0.
- cfg_start, then write 512 words with value = word index, cfg_valid held 1 -> cfg_ready drops after word 511; load_done=1; coeff is still all zero.
- cfg_commit, then 3 idle cycles, then frame_sync -> swap_pending=1 until frame_sync. Next read at count=3 returns band b = b*64+3 (band 7 = 451), one cycle after count is applied.
- Write 100 words, then cfg_commit -> cfg_err=1, state stays LOAD. Finish the remaining 412 words -> load_done=1. cfg_start clears cfg_err.
- During PENDING, cfg_start and frame_sync in the same cycle -> no swap, ptr=0, state LOAD, active outputs unchanged.
- With NUMBER_OF_TAPS=48, count=50 -> coeff=0. Async rst_n low mid-LOAD -> all outputs 0 immediately, without waiting for a clock edge.
